// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I instruction formats, base opcodes and the canonical NOP word
package rv32_pkg;
  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_L, FMT_JALR, FMT_S, FMT_AUIPC, FMT_LUI, FMT_B, FMT_J
  } fmt_e;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  function automatic logic [6:0] fmt_op(input logic [3:0] f);
    case (f)
      FMT_R:     return OP_R;
      FMT_I:     return OP_I;
      FMT_L:     return OP_L;
      FMT_JALR:  return OP_JALR;
      FMT_S:     return OP_S;
      FMT_AUIPC: return OP_AUIPC;
      FMT_LUI:   return OP_LUI;
      FMT_B:     return OP_B;
      FMT_J:     return OP_J;
      default:   return 7'd0;
    endcase
  endfunction
endpackage

// File: rtl/imm_range_chk.sv
// imm_range_chk: flags immediates that do not fit the target format's field or alignment
module imm_range_chk
  import rv32_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);
  logic fit12, fit13, fit21;
  // a value fits an n-bit signed field when all bits above n-1 equal the sign bit
  assign fit12 = &imm[31:11] | ~|imm[31:11];
  assign fit13 = &imm[31:12] | ~|imm[31:12];
  assign fit21 = &imm[31:20] | ~|imm[31:20];
  assign err = (fmt == FMT_R) ? 1'b0 :
               (fmt == FMT_I || fmt == FMT_L || fmt == FMT_JALR || fmt == FMT_S) ? !fit12 :
               (fmt == FMT_AUIPC || fmt == FMT_LUI) ? |imm[11:0] :
               (fmt == FMT_B) ? (!fit13 | imm[0]) :
               (fmt == FMT_J) ? (!fit21 | imm[0]) : 1'b1;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into instruction words through a 2-stage valid/ready pipe
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  logic        s1_v, s1_err, s2_v, s1_en, s2_en, chk_err;
  logic [3:0]  s1_fmt;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm, pack;
  assign s2_en     = !s2_v || out_ready;
  assign s1_en     = !s1_v || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_v;
  imm_range_chk u_chk (.fmt(in_fmt), .imm(in_imm), .err(chk_err));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s1_v <= 1'b0;
    else if (s1_en) s1_v <= in_valid;
  // field registers carry no state worth resetting; s1_v qualifies them
  always_ff @(posedge clk)
    if (s1_en && in_valid) begin
      s1_fmt <= in_fmt;
      s1_rd  <= in_rd;
      s1_rs1 <= in_rs1;
      s1_rs2 <= in_rs2;
      s1_f3  <= in_funct3;
      s1_f7  <= in_funct7;
      s1_imm <= in_imm;
      s1_err <= chk_err;
    end
  always_comb begin
    pack = NOP;
    case (s1_fmt)
      FMT_R:                   pack = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, OP_R};
      FMT_I, FMT_L, FMT_JALR:  pack = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, fmt_op(s1_fmt)};
      FMT_S:                   pack = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], OP_S};
      FMT_AUIPC, FMT_LUI:      pack = {s1_imm[31:12], s1_rd, fmt_op(s1_fmt)};
      FMT_B:                   pack = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                                       s1_imm[4:1], s1_imm[11], OP_B};
      FMT_J:                   pack = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                       s1_rd, OP_J};
      default:                 pack = NOP;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s2_v      <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_instr <= pack;
        out_err   <= s1_err;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      enc_cnt <= enc_cnt + 1'b1;
      if (out_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
endmodule
